// File: rtl/controle_medicao_hcsr04.sv
`default_nettype none
//============================================================================
// Module      : controle_medicao_hcsr04
// Description : Measurement sequencer for the HC-SR04 ultrasonic interface.
//               Issues a one-cycle measure request every PERIODO cycles,
//               waits up to TIMEOUT cycles for the interface ready pulse,
//               captures the 12-bit BCD distance and pulses valida. A missing
//               echo resets the interface and retries; N_TENT consecutive
//               timeouts latch erro until ligar is dropped.
//               Optional macro LIMIAR_EN adds the presente output
//               (captured distance below LIMIAR).
// Revision    : 1.0 - initial release
//============================================================================
module controle_medicao_hcsr04 #(
    parameter int          PERIODO = 5000000,
    parameter int          TIMEOUT = 2500000,
    parameter int          N_TENT  = 3,
    parameter logic [11:0] LIMIAR  = 12'h010
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        pronto_sensor,
    input  logic [11:0] medida_sensor,
    output logic        medir,
    output logic        reset_sensor,
    output logic [11:0] distancia,
    output logic        valida,
    output logic        erro,
    output logic [3:0]  db_estado
`ifdef LIMIAR_EN
    ,
    output logic        presente
`endif
);

    // Counter widths: each counter only ever holds 0 .. LIMIT-1.
    localparam int c_W_PER = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam int c_W_TO  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_W_PER-1:0] c_PER_FIM = c_W_PER'(PERIODO - 1);
    localparam logic [c_W_TO-1:0]  c_TO_FIM  = c_W_TO'(TIMEOUT - 1);
    localparam logic [3:0]         c_N_TENT  = 4'(N_TENT);

    typedef enum logic [3:0] {
        ST_INICIAL  = 4'd0,
        ST_MEDE     = 4'd1,
        ST_AGUARDA  = 4'd2,
        ST_REGISTRA = 4'd3,
        ST_ESPERA   = 4'd4,
        ST_FALHA    = 4'd5,
        ST_ERRO     = 4'd6
    } estado_t;

    estado_t              r_estado;
    logic [c_W_PER-1:0]   r_cnt_periodo;
    logic [c_W_TO-1:0]    r_cnt_timeout;
    logic [3:0]           r_tentativas;

`ifndef LIMIAR_EN
    // Threshold is only meaningful with the presence comparator built in.
    logic w_unused_limiar;
    assign w_unused_limiar = ^LIMIAR;
`endif

    // State code is taken straight from the state register.
    assign db_estado = r_estado;

    // Sequencer: state, counters and all outputs. Outputs are assigned on
    // the edge that enters a state so they are high during that state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado      <= ST_INICIAL;
            r_cnt_periodo <= '0;
            r_cnt_timeout <= '0;
            r_tentativas  <= '0;
            medir         <= 1'b0;
            reset_sensor  <= 1'b0;
            distancia     <= 12'h000;
            valida        <= 1'b0;
            erro          <= 1'b0;
`ifdef LIMIAR_EN
            presente      <= 1'b0;
`endif
        end else begin
            // Single-cycle strobes default low.
            medir        <= 1'b0;
            reset_sensor <= 1'b0;
            valida       <= 1'b0;

            // Period counter free-runs outside INICIAL so request starts
            // stay PERIODO apart regardless of the outcome of a request.
            if (r_estado != ST_INICIAL) begin
                if (r_cnt_periodo == c_PER_FIM) begin
                    r_cnt_periodo <= '0;
                end else begin
                    r_cnt_periodo <= r_cnt_periodo + 1'b1;
                end
            end

            if (!ligar) begin
                // Disable abandons everything; distancia keeps its value.
                r_estado      <= ST_INICIAL;
                r_cnt_periodo <= '0;
                r_cnt_timeout <= '0;
                r_tentativas  <= '0;
                erro          <= 1'b0;
`ifdef LIMIAR_EN
                presente      <= 1'b0;
`endif
            end else begin
                case (r_estado)
                    ST_INICIAL: begin
                        r_cnt_periodo <= '0;
                        r_cnt_timeout <= '0;
                        r_tentativas  <= '0;
                        r_estado      <= ST_MEDE;
                        medir         <= 1'b1;
                    end

                    ST_MEDE: begin
                        // Timeout counter counts cycles since the request.
                        r_cnt_timeout <= r_cnt_timeout + 1'b1;
                        r_estado      <= ST_AGUARDA;
                    end

                    ST_AGUARDA: begin
                        if (pronto_sensor) begin
                            // A ready pulse on the timeout cycle still wins.
                            distancia <= medida_sensor;
                            valida    <= 1'b1;
                            r_estado  <= ST_REGISTRA;
`ifdef LIMIAR_EN
                            presente  <= (medida_sensor < LIMIAR);
`endif
                        end else if (r_cnt_timeout == c_TO_FIM) begin
                            reset_sensor <= 1'b1;
                            r_tentativas <= r_tentativas + 1'b1;
                            r_estado     <= ST_FALHA;
                        end else begin
                            r_cnt_timeout <= r_cnt_timeout + 1'b1;
                        end
                    end

                    ST_REGISTRA: begin
                        r_tentativas <= '0;
                        r_estado     <= ST_ESPERA;
                    end

                    ST_FALHA: begin
                        // r_tentativas already includes this failure.
                        if (r_tentativas == c_N_TENT) begin
                            erro     <= 1'b1;
                            r_estado <= ST_ERRO;
`ifdef LIMIAR_EN
                            presente <= 1'b0;
`endif
                        end else begin
                            r_estado <= ST_ESPERA;
                        end
                    end

                    ST_ESPERA: begin
                        if (r_cnt_periodo == c_PER_FIM) begin
                            r_cnt_periodo <= '0;
                            r_cnt_timeout <= '0;
                            medir         <= 1'b1;
                            r_estado      <= ST_MEDE;
                        end
                    end

                    ST_ERRO: begin
                        // Held until ligar drops or reset.
                        erro <= 1'b1;
                    end

                    default: begin
                        r_estado      <= ST_INICIAL;
                        r_cnt_periodo <= '0;
                        r_cnt_timeout <= '0;
                        r_tentativas  <= '0;
                        erro          <= 1'b0;
`ifdef LIMIAR_EN
                        presente      <= 1'b0;
`endif
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controle_medicao_hcsr04.sv
`default_nettype none
//============================================================================
// Module      : tb_controle_medicao_hcsr04
// Description : Directed self-checking bench for controle_medicao_hcsr04
//               with PERIODO=100, TIMEOUT=40, N_TENT=2, LIMIAR=12'h010.
// Revision    : 1.0 - initial release
//============================================================================
module tb_controle_medicao_hcsr04;

    logic        clock;
    logic        reset;
    logic        ligar;
    logic        pronto_sensor;
    logic [11:0] medida_sensor;
    logic        medir;
    logic        reset_sensor;
    logic [11:0] distancia;
    logic        valida;
    logic        erro;
    logic [3:0]  db_estado;
`ifdef LIMIAR_EN
    logic        presente;
`endif

    int n_vec;
    int n_err;
    int cyc;

    controle_medicao_hcsr04 #(
        .PERIODO (100),
        .TIMEOUT (40),
        .N_TENT  (2),
        .LIMIAR  (12'h010)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ligar         (ligar),
        .pronto_sensor (pronto_sensor),
        .medida_sensor (medida_sensor),
        .medir         (medir),
        .reset_sensor  (reset_sensor),
        .distancia     (distancia),
        .valida        (valida),
        .erro          (erro),
        .db_estado     (db_estado)
`ifdef LIMIAR_EN
        ,
        .presente      (presente)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Advance to cycle t; sample/drive 1 time unit after the edge.
    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clock);
            cyc++;
        end
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        reset = 1'b1;
        ligar = 1'b0;
        pronto_sensor = 1'b0;
        medida_sensor = 12'h000;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc   = 0;

        // Reset state
        chk("rst_estado",   12'(db_estado),    12'd0);
        chk("rst_medir",    12'(medir),        12'd0);
        chk("rst_rsensor",  12'(reset_sensor), 12'd0);
        chk("rst_dist",     distancia,         12'h000);
        chk("rst_valida",   12'(valida),       12'd0);
        chk("rst_erro",     12'(erro),         12'd0);

        // 1: first request, capture 12'h123, next request at 101
        ligar = 1'b1;
        goto(1);
        chk("t1_medir1",    12'(medir),        12'd1);
        chk("t1_est_mede",  12'(db_estado),    12'd1);
        goto(2);
        chk("t1_medir_off", 12'(medir),        12'd0);
        chk("t1_est_agu",   12'(db_estado),    12'd2);
        goto(20);
        pronto_sensor = 1'b1;
        medida_sensor = 12'h123;
        goto(21);
        pronto_sensor = 1'b0;
        medida_sensor = 12'h000;
        chk("t1_valida",    12'(valida),       12'd1);
        chk("t1_dist",      distancia,         12'h123);
        chk("t1_est_reg",   12'(db_estado),    12'd3);
        goto(22);
        chk("t1_valida_off",12'(valida),       12'd0);
        chk("t1_est_esp",   12'(db_estado),    12'd4);
        goto(100);
        chk("t1_medir_100", 12'(medir),        12'd0);
        goto(101);
        chk("t1_medir_101", 12'(medir),        12'd1);

        // 2/3: timeout on request 101 -> reset_sensor at 141
        goto(140);
        chk("t2_rs_140",    12'(reset_sensor), 12'd0);
        goto(141);
        chk("t2_rs_141",    12'(reset_sensor), 12'd1);
        chk("t2_est_falha", 12'(db_estado),    12'd5);
        chk("t2_medir_141", 12'(medir),        12'd0);
        goto(142);
        chk("t2_est_esp",   12'(db_estado),    12'd4);
        chk("t2_erro_142",  12'(erro),         12'd0);

        // 3: successful capture of 12'h045 clears the retry count
        goto(201);
        chk("t3_medir_201", 12'(medir),        12'd1);
        goto(220);
        pronto_sensor = 1'b1;
        medida_sensor = 12'h045;
        goto(221);
        pronto_sensor = 1'b0;
        chk("t3_valida",    12'(valida),       12'd1);
        chk("t3_dist",      distancia,         12'h045);

        // 4: pronto on the timeout cycle (340) wins
        goto(340);
        chk("t4_est_340",   12'(db_estado),    12'd2);
        pronto_sensor = 1'b1;
        medida_sensor = 12'h777;
        goto(341);
        pronto_sensor = 1'b0;
        chk("t4_rs",        12'(reset_sensor), 12'd0);
        chk("t4_valida",    12'(valida),       12'd1);
        chk("t4_est_reg",   12'(db_estado),    12'd3);
        chk("t4_dist",      distancia,         12'h777);

        // 3: one timeout after a success does not raise erro
        goto(441);
        chk("t3_rs_441",    12'(reset_sensor), 12'd1);
        goto(442);
        chk("t3_est_442",   12'(db_estado),    12'd4);
        chk("t3_erro_442",  12'(erro),         12'd0);

        // 2: second consecutive timeout latches erro
        goto(541);
        chk("t2_rs_541",    12'(reset_sensor), 12'd1);
        goto(542);
        chk("t2_erro_542",  12'(erro),         12'd1);
        chk("t2_est_erro",  12'(db_estado),    12'd6);
        goto(601);
        chk("t2_no_medir",  12'(medir),        12'd0);
        chk("t2_erro_held", 12'(erro),         12'd1);
        chk("t2_dist_held", distancia,         12'h777);
        ligar = 1'b0;
        goto(602);
        chk("t2_erro_clr",  12'(erro),         12'd0);
        chk("t2_est_ini",   12'(db_estado),    12'd0);

        // 5: ligar dropped in AGUARDA, late pronto ignored
        goto(611);
        ligar = 1'b1;
        goto(612);
        chk("t5_medir",     12'(medir),        12'd1);
        goto(620);
        chk("t5_est_agu",   12'(db_estado),    12'd2);
        ligar = 1'b0;
        goto(621);
        chk("t5_est_ini",   12'(db_estado),    12'd0);
        goto(623);
        pronto_sensor = 1'b1;
        medida_sensor = 12'hABC;
        goto(624);
        pronto_sensor = 1'b0;
        chk("t5_no_valida", 12'(valida),       12'd0);
        chk("t5_dist_kept", distancia,         12'h777);

        // 6: threshold measurements 12'h009 then 12'h010
        ligar = 1'b1;
        goto(625);
        chk("t6_medir",     12'(medir),        12'd1);
        goto(630);
        pronto_sensor = 1'b1;
        medida_sensor = 12'h009;
        goto(631);
        pronto_sensor = 1'b0;
        chk("t6_dist_009",  distancia,         12'h009);
        goto(633);
`ifdef LIMIAR_EN
        chk("t6_presente1", 12'(presente),     12'd1);
`endif
        goto(725);
        chk("t6_medir_725", 12'(medir),        12'd1);
        goto(730);
        pronto_sensor = 1'b1;
        medida_sensor = 12'h010;
        goto(731);
        pronto_sensor = 1'b0;
        chk("t6_dist_010",  distancia,         12'h010);
        goto(733);
`ifdef LIMIAR_EN
        chk("t6_presente0", 12'(presente),     12'd0);
`endif

        // 5: asynchronous reset in ESPERA takes effect without a clock edge
        goto(760);
        chk("t5_est_esp",   12'(db_estado),    12'd4);
        reset = 1'b1;
        #2;
        chk("t5_ar_estado", 12'(db_estado),    12'd0);
        chk("t5_ar_dist",   distancia,         12'h000);
        chk("t5_ar_erro",   12'(erro),         12'd0);
        chk("t5_ar_medir",  12'(medir),        12'd0);
        chk("t5_ar_valida", 12'(valida),       12'd0);
        chk("t5_ar_rs",     12'(reset_sensor), 12'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
